// File: rtl/uart_link_ctrl.sv
// Link controller between N_REQ byte producers/consumers and a shared uart core.
// Round-robin TX arbitration sequenced on tx_busy; RX drains rdy/dout into a one-cycle strobe.
module uart_link_ctrl #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [ID_W-1:0]      tx_grant_id,
    output logic [7:0]           uart_din,
    output logic                 uart_wr_en,
    input  logic                 uart_tx_busy,
    input  logic                 uart_rdy,
    input  logic [7:0]           uart_dout,
    output logic                 uart_rdy_clr,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 tx_timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W:0] N_REQ_L = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {TxIdle, TxIssue, TxWaitBusy, TxWaitDone} tx_state_e;
    typedef enum logic {RxArmed, RxClear} rx_state_e;

    tx_state_e          tx_state_q, tx_state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [7:0]         din_q, din_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    rx_state_e          rx_state_q, rx_state_d;
    logic               clr_done_q, clr_done_d;
    logic [7:0]         rx_data_q, rx_data_d;

    logic [ID_W-1:0]    start_idx;
    logic [2*N_REQ-1:0] rot_full;
    logic [N_REQ-1:0]   rot;
    logic               pick_found;
    logic [ID_W-1:0]    pick_ofs;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    pick_idx;
    logic [7:0]         pick_byte;

    // Rotate valids so bit 0 is the requester right after the last grant, then take the first set.
    always_comb begin
        start_idx  = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
        rot_full   = {req_valid, req_valid} >> start_idx;
        rot        = rot_full[N_REQ-1:0];
        pick_found = 1'b0;
        pick_ofs   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!pick_found && rot[j]) begin
                pick_found = 1'b1;
                pick_ofs   = ID_W'(j);
            end
        end
        pick_sum = {1'b0, start_idx} + {1'b0, pick_ofs};
        if (pick_sum >= N_REQ_L) begin
            pick_sum = pick_sum - N_REQ_L;
        end
        pick_idx  = pick_sum[ID_W-1:0];
        pick_byte = 8'h00;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        tx_state_d     = tx_state_q;
        last_d         = last_q;
        grant_d        = grant_q;
        din_d          = din_q;
        cnt_d          = cnt_q;
        uart_wr_en     = 1'b0;
        req_ready      = '0;
        tx_timeout_err = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                // Holding off while busy also covers a reset that landed mid-frame.
                if (pick_found && !uart_tx_busy) begin
                    grant_d    = pick_idx;
                    din_d      = pick_byte;
                    tx_state_d = TxIssue;
                end
            end
            TxIssue: begin
                uart_wr_en = 1'b1;
                req_ready  = {{(N_REQ - 1){1'b0}}, 1'b1} << grant_q;
                last_d     = grant_q;
                cnt_d      = '0;
                tx_state_d = TxWaitBusy;
            end
            TxWaitBusy: begin
                if (uart_tx_busy) begin
                    tx_state_d = TxWaitDone;
                end else if (cnt_q == CNT_LAST) begin
                    // Byte is dropped, not retried.
                    tx_timeout_err = 1'b1;
                    tx_state_d     = TxIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TxWaitDone: begin
                if (!uart_tx_busy) begin
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            last_q     <= LAST_IDX;
            grant_q    <= '0;
            din_q      <= 8'h00;
            cnt_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
        end
    end

    assign uart_din    = din_q;
    assign tx_grant_id = grant_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        clr_done_d   = clr_done_q;
        rx_data_d    = rx_data_q;
        rx_valid     = 1'b0;
        uart_rdy_clr = 1'b0;
        unique case (rx_state_q)
            RxArmed: begin
                if (uart_rdy) begin
                    rx_data_d  = uart_dout;
                    clr_done_d = 1'b0;
                    rx_state_d = RxClear;
                end
            end
            RxClear: begin
                // Re-arm only once rdy has dropped so one byte is never captured twice.
                if (!clr_done_q) begin
                    rx_valid     = 1'b1;
                    uart_rdy_clr = 1'b1;
                    clr_done_d   = 1'b1;
                end else if (!uart_rdy) begin
                    rx_state_d = RxArmed;
                end
            end
            default: rx_state_d = RxArmed;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_state_q <= RxArmed;
            clr_done_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            clr_done_q <= clr_done_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: behavioural requester/core model with loopback and a
// round-robin reference picker; checks grants, bytes, timing, timeouts and RX drain.
module tb_uart_link_ctrl;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk_50m = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [1:0]     tx_grant_id;
    logic [7:0]     uart_din;
    logic           uart_wr_en;
    logic           uart_tx_busy = 1'b0;
    logic           uart_rdy = 1'b0;
    logic [7:0]     uart_dout = 8'h00;
    logic           uart_rdy_clr;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           tx_timeout_err;

    uart_link_ctrl #(
        .N_REQ       (N),
        .ID_W        (2),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk_50m       (clk_50m),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_grant_id   (tx_grant_id),
        .uart_din      (uart_din),
        .uart_wr_en    (uart_wr_en),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rdy      (uart_rdy),
        .uart_dout     (uart_dout),
        .uart_rdy_clr  (uart_rdy_clr),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_timeout_err(tx_timeout_err)
    );

    always #10 clk_50m = ~clk_50m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester byte queues
    logic [7:0] rbuf [N][512];
    int         rhead [N];
    int         rtail [N];

    // Reference state
    int         last_m = N - 1;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    bit         have_wr = 1'b0;
    int         n_wr = 0;
    int         glog [$];
    logic [7:0] dlog [$];

    // Core model
    bit         dead = 1'b0;
    bit         loopback = 1'b1;
    bit         busy_drv = 1'b0;
    int         busy_delay = 0;
    int         busy_left = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] lb_q [$];
    bit         rdy_drv = 1'b0;
    logic [7:0] dout_drv = 8'h00;
    int         rdy_gap = 0;
    logic [7:0] exp_rx [$];
    logic [7:0] rx_log [$];
    int         raise_cyc = 0;
    int         n_raise = 0;
    int         n_clr = 0;
    int         n_rx = 0;
    int         n_to = 0;
    int         to_deadline = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < N; i++) begin
            if (rhead[i] != rtail[i]) return 1'b0;
        end
        return !busy_drv && busy_delay == 0 && lb_q.size() == 0 && !rdy_drv && rdy_gap == 0
               && exp_rx.size() == 0 && to_deadline == 0;
    endfunction

    task automatic enqueue(input int i, input logic [7:0] b);
        rbuf[i][rtail[i]] = b;
        rtail[i]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rhead[i] != rtail[i]);
            req_data[8*i +: 8] = req_valid[i] ? rbuf[i][rhead[i]] : 8'h00;
        end
        uart_tx_busy = busy_drv;
        uart_rdy     = rdy_drv;
        uart_dout    = dout_drv;
    endtask

    task automatic clear_model(input bit keep_busy);
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        last_m      = N - 1;
        have_wr     = 1'b0;
        busy_delay  = 0;
        if (!keep_busy) begin
            busy_drv  = 1'b0;
            busy_left = 0;
        end
        lb_q.delete();
        exp_rx.delete();
        glog.delete();
        dlog.delete();
        rdy_drv     = 1'b0;
        rdy_gap     = 0;
        to_deadline = 0;
    endtask

    task automatic step();
        int exp_id;
        @(posedge clk_50m);
        #1;
        cyc++;

        check_eq("timeout_err", tx_timeout_err, (to_deadline != 0) && (cyc == to_deadline));
        if (tx_timeout_err) n_to++;
        if (to_deadline != 0 && cyc >= to_deadline) to_deadline = 0;

        if (uart_wr_en) begin
            exp_id = rr_pick(req_valid, last_m);
            check_eq("grant_has_req", exp_id >= 0, 1);
            if (exp_id >= 0) begin
                check_eq("req_ready", req_ready, 64'(1) << exp_id);
                check_eq("grant_id", tx_grant_id, exp_id);
                check_eq("din", uart_din, req_data[8*exp_id +: 8]);
                if (have_wr) check_eq("wr_spacing", (cyc - last_wr_cyc) >= 4, 1);
                cur_byte = req_data[8*exp_id +: 8];
                last_m   = exp_id;
                rhead[exp_id]++;
            end
            glog.push_back(int'(tx_grant_id));
            dlog.push_back(uart_din);
            have_wr     = 1'b1;
            last_wr_cyc = cyc;
            n_wr++;
            if (dead) to_deadline = cyc + TO;
            else busy_delay = $urandom_range(1, 3);
        end else begin
            check_eq("ready_quiet", req_ready, 0);
        end

        if (busy_delay > 0) begin
            busy_delay--;
            if (busy_delay == 0) begin
                busy_drv  = 1'b1;
                busy_left = $urandom_range(2, 6);
            end
        end else if (busy_drv) begin
            busy_left--;
            if (busy_left <= 0) begin
                busy_drv = 1'b0;
                if (loopback) lb_q.push_back(cur_byte);
            end
        end

        check_eq("rdy_clr_eq_valid", uart_rdy_clr, rx_valid);
        if (rx_valid) begin
            check_eq("rx_pending", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) begin
                check_eq("rx_data", rx_data, exp_rx.pop_front());
                check_eq("rx_latency", cyc, raise_cyc + 1);
            end
            rx_log.push_back(rx_data);
            n_rx++;
        end
        if (uart_rdy_clr) begin
            check_eq("clr_while_rdy", rdy_drv, 1);
            n_clr++;
            rdy_drv = 1'b0;
            rdy_gap = 2;
        end else if (!rdy_drv) begin
            if (rdy_gap > 0) begin
                rdy_gap--;
            end else if (lb_q.size() != 0) begin
                dout_drv  = lb_q.pop_front();
                rdy_drv   = 1'b1;
                raise_cyc = cyc;
                exp_rx.push_back(dout_drv);
                n_raise++;
            end
        end

        drive_inputs();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!model_idle() && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_drain"}, model_idle(), 1);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("reset_outputs", {req_ready, tx_grant_id, uart_din, uart_wr_en, uart_rdy_clr,
                                   rx_data, rx_valid, tx_timeout_err}, 0);
        clear_model(1'b0);
        drive_inputs();
        repeat (2) @(posedge clk_50m);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int rx0, clr0, to0, wr0, raise0, n;
        #2;
        do_reset();

        // Single byte on requester 1, looped back
        enqueue(1, 8'h55);
        drive_inputs();
        rx0  = n_rx;
        clr0 = n_clr;
        step();
        check_eq("t1_latency", uart_wr_en, 1);
        check_eq("t1_ready", req_ready, 4'b0010);
        check_eq("t1_din", uart_din, 8'h55);
        wait_idle("t1", 200);
        check_eq("t1_rx_count", n_rx - rx0, 1);
        check_eq("t1_clr_count", n_clr - clr0, 1);
        if (rx_log.size() != 0) check_eq("t1_rx_byte", rx_log[rx_log.size() - 1], 8'h55);

        // Contention between 0 and 2
        do_reset();
        enqueue(0, 8'hA0);
        enqueue(2, 8'hA2);
        drive_inputs();
        wait_idle("t2", 200);
        check_eq("t2_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check_eq("t2_first_id", glog[0], 0);
            check_eq("t2_second_id", glog[1], 2);
            check_eq("t2_first_byte", dlog[0], 8'hA0);
            check_eq("t2_second_byte", dlog[1], 8'hA2);
        end

        // Fairness: all four continuously valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) enqueue(i, 8'(8'h10 + i));
        end
        drive_inputs();
        wait_idle("t3", 600);
        check_eq("t3_grants", glog.size(), 12);
        for (int j = 0; j < glog.size() && j < 12; j++) begin
            check_eq("t3_order", glog[j], j % N);
            check_eq("t3_byte", dlog[j], 8'(8'h10 + j % N));
        end

        // Timeout: core never raises busy
        do_reset();
        dead = 1'b1;
        enqueue(0, 8'h31);
        enqueue(1, 8'h32);
        drive_inputs();
        to0 = n_to;
        wait_idle("t4", 200);
        dead = 1'b0;
        check_eq("t4_timeouts", n_to - to0, 2);
        check_eq("t4_grants", glog.size(), 2);
        if (glog.size() >= 2) check_eq("t4_next_served", glog[1], 1);

        // Random mixed traffic
        do_reset();
        raise0 = n_raise;
        rx0    = n_rx;
        clr0   = n_clr;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                enqueue(int'($urandom_range(0, N - 1)), 8'($urandom_range(0, 255)));
                drive_inputs();
            end
            step();
        end
        wait_idle("t5", 3000);
        check_eq("t5_rx_vs_raise", n_rx - rx0, n_raise - raise0);
        check_eq("t5_clr_vs_raise", n_clr - clr0, n_raise - raise0);

        // Sustained RX of 0x00..0xFF
        do_reset();
        rx_log.delete();
        clr0 = n_clr;
        for (int i = 0; i < 256; i++) enqueue(0, 8'(i));
        drive_inputs();
        wait_idle("t6", 8000);
        check_eq("t6_rx_count", rx_log.size(), 256);
        check_eq("t6_clr_count", n_clr - clr0, 256);
        for (int i = 0; i < rx_log.size() && i < 256; i++) check_eq("t6_rx_order", rx_log[i], i);

        // Reset during WAIT_DONE with core still busy afterwards
        loopback = 1'b0;
        enqueue(0, 8'h77);
        drive_inputs();
        n = 0;
        while (!busy_drv && n < 50) begin
            step();
            n++;
        end
        step();
        check_eq("t7_midframe_busy", busy_drv, 1);
        #5;
        rst = 1'b1;
        #1;
        check_eq("t7_async_outputs", {req_ready, tx_grant_id, uart_din, uart_wr_en, uart_rdy_clr,
                                      rx_data, rx_valid, tx_timeout_err}, 0);
        clear_model(1'b1);
        busy_drv  = 1'b1;
        busy_left = 8;
        for (int i = 0; i < N; i++) enqueue(i, 8'(8'hC0 + i));
        drive_inputs();
        repeat (2) @(posedge clk_50m);
        #1;
        rst = 1'b0;
        wr0 = n_wr;
        repeat (6) step();
        check_eq("t7_no_wr_while_busy", n_wr - wr0, 0);
        n = 0;
        while (n_wr == wr0 && n < 40) begin
            step();
            n++;
        end
        check_eq("t7_grant_after_busy", n_wr > wr0, 1);
        if (glog.size() != 0) check_eq("t7_first_id", glog[0], 0);
        wait_idle("t7", 400);
        loopback = 1'b1;

        check_eq("final_clr_vs_raise", n_clr, n_raise);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_link_ctrl.md
# uart_link_ctrl

Controller sitting between several on-chip byte producers/consumers and the shared `uart` core. On the transmit side it round-robin arbitrates up to `N_REQ` requesters onto the single `din`/`wr_en` port, sequencing each byte against `tx_busy`. On the receive side it drains the core's `rdy`/`dout` flag, presents each received byte as a one-cycle strobe and acknowledges the core with `rdy_clr`.

## Interface
- `N_REQ`, 4: number of TX requesters (2..8).
- `ID_W`, 2: width of grant index, must equal clog2(`N_REQ`).
- `BUSY_TIMEOUT`, 16: cycles allowed after `wr_en` for `tx_busy` to rise.

- `clk_50m`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte pending; held until matching `req_ready`.
- `req_data`  in  8*N_REQ  requester i byte at bits [8i+7:8i]; stable while valid.
- `req_ready`  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `tx_grant_id`  out  ID_W  index of requester of the byte currently in flight.
- `uart_din`  out  8  byte to core `din`.
- `uart_wr_en`  out  1  one-cycle write strobe to core `wr_en`.
- `uart_tx_busy`  in  1  core `tx_busy`.
- `uart_rdy`  in  1  core `rdy`.
- `uart_dout`  in  8  core `dout`.
- `uart_rdy_clr`  out  1  one-cycle pulse to core `rdy_clr`.
- `rx_data`  out  8  last received byte, held until next.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` new.
- `tx_timeout_err`  out  1  one-cycle pulse: `tx_busy` never rose.

## Operation
- Reset: all outputs 0, TX FSM IDLE, RX FSM ARMED, RR pointer `last` = N_REQ-1 (requester 0 highest priority first).
- TX FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any `req_valid` and `uart_tx_busy`=0, select first valid index scanning `last`+1, `last`+2, … mod N_REQ; register index and byte; -> ISSUE. If `uart_tx_busy`=1, stay (covers reset during a core transfer).
  - ISSUE (exactly 1 cycle): `uart_wr_en`=1, `uart_din`=byte, `req_ready[idx]`=1, `last`<=idx, timeout counter cleared; -> WAIT_BUSY.
  - WAIT_BUSY: `uart_tx_busy`=1 -> WAIT_DONE; else count; counter reaching `BUSY_TIMEOUT` -> pulse `tx_timeout_err`, -> IDLE.
  - WAIT_DONE: `uart_tx_busy`=0 -> IDLE.
- `uart_din`, `tx_grant_id` hold last issued value outside ISSUE.
- Requester dropping `req_valid` before grant: simply not considered; no error.
- RX FSM states: ARMED, CLEAR.
  - ARMED: `uart_rdy`=1 -> capture `uart_dout` into `rx_data`, `rx_valid`=1 next cycle, -> CLEAR.
  - CLEAR: `uart_rdy_clr`=1 for one cycle, then wait for `uart_rdy`=0 before -> ARMED (no double capture of one byte).
- TX and RX FSMs independent; simultaneous grant and receive both proceed in the same cycle.

## Timing
- `req_valid` rising at cycle t with FSM in IDLE and core idle: `uart_wr_en` and `req_ready` high at t+1.
- Minimum spacing between `uart_wr_en` pulses: ISSUE + ≥1 WAIT_BUSY + ≥1 WAIT_DONE + IDLE = 4 cycles plus core frame time.
- Timeout: `tx_timeout_err` asserted BUSY_TIMEOUT cycles after ISSUE cycle; at most one per issued byte; byte is considered consumed (no retry).
- `uart_rdy` rising at cycle t: `rx_data` valid and `rx_valid` high at t+1, `uart_rdy_clr` high at t+1 (single pulse).
- `rst` asserted anywhere: outputs go 0 immediately (asynchronous), any in-flight strobe truncated; after release, first grant waits for `uart_tx_busy`=0.

## Test plan
- Single byte: requester 1 valid with 0x55, core looped tx->rx -> one `uart_wr_en` with `uart_din`=0x55, `req_ready`=4'b0010, later `rx_valid` with `rx_data`=0x55, exactly one `uart_rdy_clr`.
- Contention: requesters 0 and 2 valid same cycle (0xA0, 0xA2) after reset -> transmit order 0xA0 then 0xA2, `tx_grant_id` 0 then 2.
- Fairness: all four continuously valid with bytes 0x10+i for 12 bytes -> grant sequence 0,1,2,3 repeated 3 times, no requester granted twice while another waits.
- Timeout: `uart_tx_busy` forced 0 -> `tx_timeout_err` pulse exactly 16 cycles after `uart_wr_en`, FSM returns IDLE, next requester served.
- Sustained RX: 256 loopback bytes 0x00..0xFF -> 256 `rx_valid` strobes in order, no duplicates, `rdy` always cleared.
- Reset mid-frame: assert `rst` during WAIT_DONE -> all outputs 0 same cycle; after release with core still busy, no `uart_wr_en` until `uart_tx_busy` falls, then requester 0 granted first.
